// File: rtl/tlb_walker_if.sv
// Bundle of the miss, memory, fill and fault channels between the TLB, the page
// walker and memory. The walker uses the master view, its environment the slave view.
interface tlb_walker_if #(
    parameter int WAYS   = 8,
    parameter int PCID_W = 12
);
    localparam int WAY_W = $clog2(WAYS);

    logic              miss_valid;
    logic              miss_ready;
    logic [63:0]       miss_vaddr;
    logic [PCID_W-1:0] miss_pcid;
    logic [63:0]       cr3;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [63:0]       mem_req_addr;
    logic              mem_rsp_valid;
    logic [63:0]       mem_rsp_data;

    logic              fill_valid;
    logic [63:0]       fill_va;
    logic [63:0]       fill_pa;
    logic [PCID_W-1:0] fill_pcid;
    logic [WAY_W-1:0]  fill_way;

    logic              fault_valid;
    logic [1:0]        fault_cause;
    logic [1:0]        fault_level;

    modport master (
        input  miss_valid, miss_vaddr, miss_pcid, cr3,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output miss_ready, mem_req_valid, mem_req_addr,
        output fill_valid, fill_va, fill_pa, fill_pcid, fill_way,
        output fault_valid, fault_cause, fault_level
    );

    modport slave (
        output miss_valid, miss_vaddr, miss_pcid, cr3,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  miss_ready, mem_req_valid, mem_req_addr,
        input  fill_valid, fill_va, fill_pa, fill_pcid, fill_way,
        input  fault_valid, fault_cause, fault_level
    );
endinterface

// File: rtl/tlb_walker.sv
// Four-level x86-64 page-table walker: takes a TLB miss, issues one PTE read at a
// time, and ends with either a one-cycle TLB fill or a one-cycle fault strobe.
module tlb_walker #(
    parameter int WAYS   = 8,
    parameter int PCID_W = 12
) (
    input logic         clk,
    input logic         rst_n,
    tlb_walker_if.master bus
);
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FILL,
        S_FAULT
    } state_t;

    localparam logic [1:0] CAUSE_NOT_PRESENT  = 2'b01;
    localparam logic [1:0] CAUSE_NON_CANONICAL = 2'b10;

    state_t            r_state;
    logic [63:12]      r_va;
    logic [PCID_W-1:0] r_pcid;
    logic [1:0]        r_level;
    logic [WAY_W-1:0]  r_way_ptr;

    logic              r_miss_ready;
    logic              r_req_valid;
    logic [63:0]       r_req_addr;
    logic              r_fill_valid;
    logic [63:0]       r_fill_va;
    logic [63:0]       r_fill_pa;
    logic [PCID_W-1:0] r_fill_pcid;
    logic [WAY_W-1:0]  r_fill_way;
    logic              r_fault_valid;
    logic [1:0]        r_fault_cause;
    logic [1:0]        r_fault_level;

    logic              w_canonical;

    // Bits 63:47 must be a sign extension of bit 47.
    assign w_canonical = (&bus.miss_vaddr[63:47]) | ~(|bus.miss_vaddr[63:47]);

    function automatic logic [8:0] va_idx(input logic [63:12] va, input logic [1:0] lvl);
        logic [8:0] idx;
        case (lvl)
            2'd0:    idx = va[47:39];
            2'd1:    idx = va[38:30];
            2'd2:    idx = va[29:21];
            default: idx = va[20:12];
        endcase
        return idx;
    endfunction

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked block and every
        // register, including the strobes and held fill/fault fields, gets a value here.
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_va          <= '0;
            r_pcid        <= '0;
            r_level       <= '0;
            r_way_ptr     <= '0;
            r_miss_ready  <= 1'b1;
            r_req_valid   <= 1'b0;
            r_req_addr    <= '0;
            r_fill_valid  <= 1'b0;
            r_fill_va     <= '0;
            r_fill_pa     <= '0;
            r_fill_pcid   <= '0;
            r_fill_way    <= '0;
            r_fault_valid <= 1'b0;
            r_fault_cause <= '0;
            r_fault_level <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the
            // pre-edge values of r_level, r_way_ptr etc. regardless of statement order.
            case (r_state)
                S_IDLE: begin
                    if (bus.miss_valid && r_miss_ready) begin
                        r_va         <= bus.miss_vaddr[63:12];
                        r_pcid       <= bus.miss_pcid;
                        r_level      <= 2'd0;
                        r_miss_ready <= 1'b0;
                        if (!w_canonical) begin
                            r_state       <= S_FAULT;
                            r_fault_valid <= 1'b1;
                            r_fault_cause <= CAUSE_NON_CANONICAL;
                            r_fault_level <= 2'd0;
                        end else begin
                            // The root is only needed for the first PTE address, so it
                            // is folded into the request address instead of stored.
                            r_state     <= S_REQ;
                            r_req_valid <= 1'b1;
                            r_req_addr  <= {12'h0, bus.cr3[51:12], bus.miss_vaddr[47:39], 3'b000};
                        end
                    end
                end

                S_REQ: begin
                    if (bus.mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        if (!bus.mem_rsp_data[0]) begin
                            r_state       <= S_FAULT;
                            r_fault_valid <= 1'b1;
                            r_fault_cause <= CAUSE_NOT_PRESENT;
                            r_fault_level <= r_level;
                        end else if (r_level == 2'd3) begin
                            r_state      <= S_FILL;
                            r_fill_valid <= 1'b1;
                            r_fill_va    <= {r_va, 12'h0};
                            r_fill_pa    <= {12'h0, bus.mem_rsp_data[51:12], 12'h0};
                            r_fill_pcid  <= r_pcid;
                            r_fill_way   <= r_way_ptr;
                            r_way_ptr    <= r_way_ptr + WAY_W'(1);
                        end else begin
                            r_state     <= S_REQ;
                            r_level     <= r_level + 2'd1;
                            r_req_valid <= 1'b1;
                            r_req_addr  <= {12'h0, bus.mem_rsp_data[51:12],
                                            va_idx(r_va, r_level + 2'd1), 3'b000};
                        end
                    end
                end

                S_FILL: begin
                    r_fill_valid <= 1'b0;
                    r_miss_ready <= 1'b1;
                    r_state      <= S_IDLE;
                end

                S_FAULT: begin
                    r_fault_valid <= 1'b0;
                    r_miss_ready  <= 1'b1;
                    r_state       <= S_IDLE;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_miss_ready <= 1'b1;
                    r_req_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.miss_ready    = r_miss_ready;
    assign bus.mem_req_valid = r_req_valid;
    assign bus.mem_req_addr  = r_req_addr;
    assign bus.fill_valid    = r_fill_valid;
    assign bus.fill_va       = r_fill_va;
    assign bus.fill_pa       = r_fill_pa;
    assign bus.fill_pcid     = r_fill_pcid;
    assign bus.fill_way      = r_fill_way;
    assign bus.fault_valid   = r_fault_valid;
    assign bus.fault_cause   = r_fault_cause;
    assign bus.fault_level   = r_fault_level;
endmodule

// File: tb/tb_tlb_walker.sv
// Directed bench for tlb_walker: a small PTE memory with one-cycle responses, strobe
// monitors, and hand-computed walks covering fill, faults, round-robin ways, stalls, reset.
module tb_tlb_walker;
    localparam int WAYS   = 8;
    localparam int PCID_W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tlb_walker_if #(.WAYS(WAYS), .PCID_W(PCID_W)) bus ();

    tlb_walker #(.WAYS(WAYS), .PCID_W(PCID_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] pte_mem [logic [63:0]];
    logic [63:0] req_addrs [$];
    bit          pending   = 1'b0;
    bit          force_rsp = 1'b0;
    logic [63:0] pend_addr;
    int          fill_cnt  = 0;
    int          fault_cnt = 0;

    localparam logic [63:0] VA_OK  = 64'h0000_7FFF_FFFF_F000;
    localparam logic [63:0] VA_NC  = 64'h0000_8000_0000_0000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_read(input logic [63:0] a);
        return pte_mem.exists(a) ? pte_mem[a] : 64'h0;
    endfunction

    // Memory model: a request seen at a negedge is answered during the next cycle.
    initial begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            bus.mem_rsp_valid = pending || force_rsp;
            if (pending)        bus.mem_rsp_data = mem_read(pend_addr);
            else if (force_rsp) bus.mem_rsp_data = 64'h5003;
            pending = 1'b0;
            if (rst_n && bus.mem_req_valid && bus.mem_req_ready) begin
                pending   = 1'b1;
                pend_addr = bus.mem_req_addr;
                req_addrs.push_back(bus.mem_req_addr);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.fill_valid)  fill_cnt++;
            if (bus.fault_valid) fault_cnt++;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Returns in cycle T+1 where T is the accepting edge.
    task automatic issue_miss(input logic [63:0] va, input logic [PCID_W-1:0] pcid);
        int n = 0;
        while (!bus.miss_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("miss_ready_wait", {63'h0, bus.miss_ready}, 64'h1);
        bus.miss_valid = 1'b1;
        bus.miss_vaddr = va;
        bus.miss_pcid  = pcid;
        @(posedge clk); #1;
        bus.miss_valid = 1'b0;
    endtask

    // Latency counts cycles from the accepting edge: cycle T+n gives n.
    task automatic wait_strobe(output int n);
        n = 1;
        while (!(bus.fill_valid || bus.fault_valid) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(bus.fill_valid || bus.fault_valid)) check("strobe_timeout", 64'h0, 64'h1);
    endtask

    initial begin
        int lat;
        int fc0;
        int fl0;
        int nreq0;

        bus.miss_valid    = 1'b0;
        bus.miss_vaddr    = '0;
        bus.miss_pcid     = '0;
        bus.cr3           = 64'h1000;
        bus.mem_req_ready = 1'b1;

        pte_mem[64'h17F8]  = 64'h2003;
        pte_mem[64'h2FF8]  = 64'h3003;
        pte_mem[64'h3FF8]  = 64'h4003;
        pte_mem[64'h4FF8]  = 64'h5003;
        pte_mem[64'h107F8] = 64'h11003;
        pte_mem[64'h11FF8] = 64'h12003;

        do_reset();
        @(posedge clk); #1;
        check("rst_miss_ready",  {63'h0, bus.miss_ready},    64'h1);
        check("rst_req_valid",   {63'h0, bus.mem_req_valid}, 64'h0);
        check("rst_fill_valid",  {63'h0, bus.fill_valid},    64'h0);
        check("rst_fault_valid", {63'h0, bus.fault_valid},   64'h0);
        check("rst_fill_way",    64'(bus.fill_way),          64'h0);
        check("rst_fill_pa",     bus.fill_pa,                64'h0);

        // 1: full successful walk
        req_addrs.delete();
        issue_miss(VA_OK, 12'hABC);
        check("t1_req_valid_t1", {63'h0, bus.mem_req_valid}, 64'h1);
        check("t1_req_addr0",    bus.mem_req_addr,           64'h17F8);
        wait_strobe(lat);
        check("t1_latency",    64'(lat),             64'd9);
        check("t1_fill_valid", {63'h0, bus.fill_valid}, 64'h1);
        check("t1_fill_pa",    bus.fill_pa,          64'h5000);
        check("t1_fill_va",    bus.fill_va,          64'h0000_7FFF_FFFF_F000);
        check("t1_fill_pcid",  64'(bus.fill_pcid),   64'hABC);
        check("t1_fill_way",   64'(bus.fill_way),    64'h0);
        check("t1_nreq",       64'(req_addrs.size()), 64'd4);
        if (req_addrs.size() == 4) begin
            check("t1_addr1", req_addrs[1], 64'h2FF8);
            check("t1_addr2", req_addrs[2], 64'h3FF8);
            check("t1_addr3", req_addrs[3], 64'h4FF8);
        end
        check("t1_ready_in_fill", {63'h0, bus.miss_ready}, 64'h0);
        @(posedge clk); #1;
        check("t1_fill_drop",  {63'h0, bus.fill_valid}, 64'h0);
        check("t1_ready_back", {63'h0, bus.miss_ready}, 64'h1);
        check("t1_fill_hold",  bus.fill_pa,            64'h5000);

        // 2: non-canonical address
        nreq0 = req_addrs.size();
        issue_miss(VA_NC, 12'h001);
        check("t2_fault_valid", {63'h0, bus.fault_valid}, 64'h1);
        check("t2_fault_cause", 64'(bus.fault_cause),     64'h2);
        check("t2_fault_level", 64'(bus.fault_level),     64'h0);
        check("t2_no_req_now",  {63'h0, bus.mem_req_valid}, 64'h0);
        @(posedge clk); #1;
        check("t2_fault_drop",  {63'h0, bus.fault_valid}, 64'h0);
        check("t2_no_mem_req",  64'(req_addrs.size() - nreq0), 64'd0);

        // 3: level-2 PTE not present
        bus.cr3 = 64'h10000;
        req_addrs.delete();
        fc0 = fill_cnt;
        issue_miss(VA_OK, 12'h002);
        wait_strobe(lat);
        check("t3_fault_valid", {63'h0, bus.fault_valid}, 64'h1);
        check("t3_fault_cause", 64'(bus.fault_cause),     64'h1);
        check("t3_fault_level", 64'(bus.fault_level),     64'h2);
        @(posedge clk); #1;
        check("t3_nreq",    64'(req_addrs.size()), 64'd3);
        check("t3_no_fill", 64'(fill_cnt - fc0),   64'd0);
        bus.cr3 = 64'h1000;

        // 4: round-robin ways, fault in between leaves the pointer alone
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                issue_miss(VA_NC, 12'h003);
                check("t4_mid_fault", {63'h0, bus.fault_valid}, 64'h1);
            end
            issue_miss(VA_OK, 12'(i));
            wait_strobe(lat);
            check($sformatf("t4_fill_valid_%0d", i), {63'h0, bus.fill_valid}, 64'h1);
            check($sformatf("t4_fill_way_%0d", i),   64'(bus.fill_way),       64'(i % WAYS));
        end

        // 5: memory stalls for five cycles
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        req_addrs.delete();
        issue_miss(VA_OK, 12'h055);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5_valid_%0d", i), {63'h0, bus.mem_req_valid}, 64'h1);
            check($sformatf("t5_addr_%0d", i),  bus.mem_req_addr,           64'h17F8);
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        check("t5_none_taken", 64'(req_addrs.size()), 64'd0);
        bus.mem_req_ready = 1'b1;
        wait_strobe(lat);
        check("t5_fill_valid", {63'h0, bus.fill_valid}, 64'h1);
        check("t5_fill_pa",    bus.fill_pa,             64'h5000);
        check("t5_nreq",       64'(req_addrs.size()),   64'd4);
        if (req_addrs.size() > 0) check("t5_first_addr", req_addrs[0], 64'h17F8);

        // 6: reset during WAIT, then a stale response
        @(posedge clk); #1;
        issue_miss(VA_OK, 12'h066);
        @(posedge clk); #1;
        check("t6_in_wait", {63'h0, bus.mem_req_valid}, 64'h0);
        fc0 = fill_cnt;
        fl0 = fault_cnt;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        force_rsp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("t6_ready_%0d", i), {63'h0, bus.miss_ready},    64'h1);
            check($sformatf("t6_req_%0d", i),   {63'h0, bus.mem_req_valid}, 64'h0);
            check($sformatf("t6_fill_%0d", i),  {63'h0, bus.fill_valid},    64'h0);
        end
        force_rsp = 1'b0;
        @(posedge clk); #1;
        check("t6_no_fill",  64'(fill_cnt - fc0),  64'd0);
        check("t6_no_fault", 64'(fault_cnt - fl0), 64'd0);
        issue_miss(VA_OK, 12'h077);
        wait_strobe(lat);
        check("t6_after_latency", 64'(lat),           64'd9);
        check("t6_after_way",     64'(bus.fill_way),  64'h0);
        check("t6_after_pcid",    64'(bus.fill_pcid), 64'h077);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
